block_dispatch: RTL and testbench
=================================

BLOCK_DISPATCH -- requirements
Module: block_dispatch

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of compute cores served.
REQ-002 SHALL have parameter THREADS_PER_BLOCK, default 4, threads per block; power of two assumed by the core.
REQ-003 SHALL define TC_BITS = $clog2(THREADS_PER_BLOCK)+1.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: start  input  1  kernel launch request, level.
REQ-007 Port: thread_count  input  8  total kernel threads, sampled at launch.
REQ-008 Port: core_done  input  NUM_CORES  per-core block-complete flag, level, from each core.
REQ-009 Port: core_start  output  NUM_CORES  per-core block start, level, held until that core's core_done.
REQ-010 Port: core_reset  output  NUM_CORES  per-core one-cycle reset pulse.
REQ-011 Port: core_block_id  output  NUM_CORES*8  flattened block index per core, core i at bits [8i+7:8i].
REQ-012 Port: core_thread_count  output  NUM_CORES*TC_BITS  flattened active-thread count per core.
REQ-013 Port: done  output  1  kernel complete.

Function
REQ-014 SHALL implement states IDLE, INIT, RUN, DONE.
REQ-015 IDLE or DONE with start=1 at an edge: latch thread_count, total_blocks = ceil(thread_count/THREADS_PER_BLOCK) (9-bit-safe arithmetic, no overflow at 255), clear dispatched/completed counters, done<=0, core_reset<=all ones, go INIT.
REQ-016 INIT: core_reset<=0, go RUN next edge; core_start stays 0.
REQ-017 start SHALL be ignored in INIT and RUN.
REQ-018 RUN: a core is free when core_start[i]=0 and core_reset[i]=0; at each edge every free core, ascending index, SHALL receive the next undispatched block while dispatched < total_blocks.
REQ-019 On assignment: core_start[i]<=1, core_block_id[i]<=block index, core_thread_count[i]<=THREADS_PER_BLOCK, except the last block gets thread_count mod THREADS_PER_BLOCK when nonzero.
REQ-020 core_done[i] SHALL be honoured only while core_start[i]=1; then core_start[i]<=0, core_reset[i]<=1 for exactly one cycle, completed counter += 1.
REQ-021 Simultaneous core_done on k cores SHALL add k to the completed counter in one edge.
REQ-022 A core whose reset pulse is active SHALL NOT be reassigned until the following edge.
REQ-023 RUN with completed == total_blocks: done<=1, go DONE; done held until next accepted start.
REQ-024 thread_count=0: total_blocks=0; RUN transitions to DONE at first RUN edge, no core_start pulse.
REQ-025 Blocks beyond available cores SHALL wait; no block dispatched twice, none skipped.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, counters 0, core_start=0, core_reset=0, core_block_id=0, core_thread_count=0, done=0, regardless of state.
REQ-027 Deassertion mid-kernel SHALL NOT resume the aborted kernel; a new start is required.

Configuration
REQ-028 Macro DISPATCH_PERF_EN SHALL, when defined, add output kernel_cycles (32 bits): cleared at launch, incremented every cycle in INIT and RUN, frozen in DONE, saturating at all ones, 0 on reset.
REQ-029 Without DISPATCH_PERF_EN the port and counter SHALL be absent; other behaviour identical.

Verification (NUM_CORES=2, THREADS_PER_BLOCK=4)
REQ-030 thread_count=8, start pulse -> core_start=2'b11 two edges after launch edge; ids 0/1, counts 4/4; both core_done -> one-cycle core_reset=2'b11, done=1 next edge.
REQ-031 thread_count=10 -> blocks 0,1 (count 4) dispatched together; core1 done first -> core1 reset pulse, then core1 gets id 2 count 2; done after all three complete.
REQ-032 thread_count=0 -> core_start never asserted, done=1 two edges after launch.
REQ-033 core_done both high same cycle with 2 blocks outstanding -> counter +2, done next edge.
REQ-034 reset asserted in RUN with core_start=2'b11 -> all outputs 0 without clock edge; start ignored until reset released.
REQ-035 DISPATCH_PERF_EN, thread_count=4, core_done 5 cycles after core_start -> kernel_cycles matches INIT+RUN cycle count, holds in DONE.

Source files
------------

// File: rtl/block_dispatch.sv
// rtl/block_dispatch.sv - kernel block dispatcher; optional DISPATCH_PERF_EN adds kernel_cycles
module block_dispatch #(
  parameter  int NUM_CORES         = 2,
  parameter  int THREADS_PER_BLOCK = 4,
  localparam int TC_BITS           = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [7:0]                     thread_count,
  input  logic [NUM_CORES-1:0]           core_done,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES-1:0]           core_reset,
  output logic [NUM_CORES*8-1:0]         core_block_id,
  output logic [NUM_CORES*TC_BITS-1:0]   core_thread_count,
`ifdef DISPATCH_PERF_EN
  output logic [31:0]                    kernel_cycles,
`endif
  output logic                           done
);

  localparam int SHIFT = $clog2(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  state_t                         state, state_nxt;
  logic [7:0]                     tc_q, tc_nxt;
  logic [8:0]                     total_q, total_nxt;
  logic [8:0]                     disp_q, disp_nxt;
  logic [8:0]                     comp_q, comp_nxt;
  logic                           done_nxt;
  logic [NUM_CORES-1:0]           start_nxt, reset_nxt;
  logic [NUM_CORES*8-1:0]         id_nxt;
  logic [NUM_CORES*TC_BITS-1:0]   cnt_nxt;

  logic [8:0]                     launch_blocks;
  logic [7:0]                     rem;
  logic [TC_BITS-1:0]             last_cnt;
  logic [8:0]                     run_idx, run_comp;

  // Nine-bit ceiling division so a 255-thread launch cannot wrap.
  assign launch_blocks = ({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> SHIFT;
  assign rem           = tc_q & 8'(THREADS_PER_BLOCK - 1);
  assign last_cnt      = (rem != 8'd0) ? TC_BITS'(rem) : TC_BITS'(THREADS_PER_BLOCK);

  // Next-state, completion accounting and block assignment.
  always_comb begin
    state_nxt = state;
    tc_nxt    = tc_q;
    total_nxt = total_q;
    disp_nxt  = disp_q;
    comp_nxt  = comp_q;
    done_nxt  = done;
    start_nxt = core_start;
    reset_nxt = core_reset;
    id_nxt    = core_block_id;
    cnt_nxt   = core_thread_count;
    run_idx   = disp_q;
    run_comp  = comp_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          tc_nxt    = thread_count;
          total_nxt = launch_blocks;
          disp_nxt  = 9'd0;
          comp_nxt  = 9'd0;
          done_nxt  = 1'b0;
          reset_nxt = '1;
          state_nxt = INIT;
        end
      end
      INIT: begin
        reset_nxt = '0;
        state_nxt = RUN;
      end
      RUN: begin
        // Reset pulses last exactly one cycle; a pulsing core is not free this edge.
        reset_nxt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (core_start[i] && core_done[i]) begin
            start_nxt[i] = 1'b0;
            reset_nxt[i] = 1'b1;
            run_comp     = run_comp + 9'd1;
          end else if (!core_start[i] && !core_reset[i] && (run_idx < total_q)) begin
            start_nxt[i]                    = 1'b1;
            id_nxt[i*8 +: 8]                = run_idx[7:0];
            cnt_nxt[i*TC_BITS +: TC_BITS]   = (run_idx == total_q - 9'd1) ?
                                              last_cnt : TC_BITS'(THREADS_PER_BLOCK);
            run_idx                         = run_idx + 9'd1;
          end
        end
        disp_nxt = run_idx;
        comp_nxt = run_comp;
        if (comp_q == total_q) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any kernel in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      tc_q              <= 8'd0;
      total_q           <= 9'd0;
      disp_q            <= 9'd0;
      comp_q            <= 9'd0;
      done              <= 1'b0;
      core_start        <= '0;
      core_reset        <= '0;
      core_block_id     <= '0;
      core_thread_count <= '0;
    end else begin
      state             <= state_nxt;
      tc_q              <= tc_nxt;
      total_q           <= total_nxt;
      disp_q            <= disp_nxt;
      comp_q            <= comp_nxt;
      done              <= done_nxt;
      core_start        <= start_nxt;
      core_reset        <= reset_nxt;
      core_block_id     <= id_nxt;
      core_thread_count <= cnt_nxt;
    end
  end

`ifdef DISPATCH_PERF_EN
  // Saturating count of INIT and RUN cycles, cleared on each accepted launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kernel_cycles <= 32'd0;
    end else if (((state == IDLE) || (state == DONE)) && start) begin
      kernel_cycles <= 32'd0;
    end else if (((state == INIT) || (state == RUN)) && (kernel_cycles != 32'hFFFF_FFFF)) begin
      kernel_cycles <= kernel_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_dispatch.sv
// tb/tb_block_dispatch.sv - self-checking bench for block_dispatch
`timescale 1ns/1ps
module tb_block_dispatch;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int TCB = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [7:0]           thread_count;
  logic [NC-1:0]        core_done;
  logic [NC-1:0]        core_start;
  logic [NC-1:0]        core_reset;
  logic [NC*8-1:0]      core_block_id;
  logic [NC*TCB-1:0]    core_thread_count;
  logic                 done;
`ifdef DISPATCH_PERF_EN
  logic [31:0]          kernel_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  block_dispatch #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .thread_count      (thread_count),
    .core_done         (core_done),
    .core_start        (core_start),
    .core_reset        (core_reset),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
`ifdef DISPATCH_PERF_EN
    .kernel_cycles     (kernel_cycles),
`endif
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] tc);
    thread_count = tc;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  function automatic int blocks_for(input int tc);
    return (tc + TPB - 1) / TPB;
  endfunction

  function automatic int count_for(input int tc, input int b);
    if ((b == blocks_for(tc) - 1) && (tc % TPB != 0)) return tc % TPB;
    return TPB;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start"}, core_start, 2'b00);
    check({tag, "_reset"}, core_reset, 2'b00);
    check({tag, "_id"},    core_block_id, 16'h0000);
    check({tag, "_cnt"},   core_thread_count, 6'd0);
    check({tag, "_done"},  done, 1'b0);
  endtask

  // Launch a kernel and emulate cores with random latency, comparing against the dispatch rules.
  task automatic run_kernel(input int tc, input int max_lat);
    int            total, assigned, completed, cyc, slots;
    int            lat [NC];
    bit            fin, exp_done;
    logic [NC-1:0] prev_start, prev_reset, accept, exp_new, exp_start;
    total = blocks_for(tc);
    core_done = '0;
    launch(tc[7:0]);
    check("launch_reset", core_reset, 2'b11);
    check("launch_done", done, 1'b0);
    tick();
    check("init_reset", core_reset, 2'b00);
    check("init_start", core_start, 2'b00);
    prev_start = core_start;
    prev_reset = core_reset;
    accept     = '0;
    assigned   = 0;
    completed  = 0;
    fin        = 1'b0;
    for (int i = 0; i < NC; i++) lat[i] = 0;
    for (cyc = 0; (cyc < 3000) && !fin; cyc++) begin
      exp_done = (completed == total);
      exp_new  = '0;
      slots    = total - assigned;
      for (int i = 0; i < NC; i++) begin
        if (!prev_start[i] && !prev_reset[i] && (slots > 0)) begin
          exp_new[i] = 1'b1;
          slots--;
        end
      end
      tick();
      exp_start = (prev_start & ~accept) | exp_new;
      check("run_start", core_start, exp_start);
      check("run_reset_pulse", core_reset, accept);
      for (int i = 0; i < NC; i++) begin
        if (exp_new[i]) begin
          check("blk_id", core_block_id[i*8 +: 8], assigned[7:0]);
          check("blk_cnt", core_thread_count[i*TCB +: TCB], count_for(tc, assigned));
          assigned++;
        end
      end
      completed += $countones(accept);
      check("run_done", done, exp_done);
      if (done) fin = 1'b1;
      for (int i = 0; i < NC; i++) begin
        if (accept[i]) core_done[i] = 1'b0;
        if (exp_new[i]) lat[i] = $urandom_range(max_lat, 0);
        if (exp_start[i] && !core_done[i]) begin
          if (lat[i] == 0) core_done[i] = 1'b1;
          else lat[i]--;
        end
      end
      accept     = core_done & exp_start;
      prev_start = core_start;
      prev_reset = core_reset;
    end
    check("kernel_finished", fin, 1'b1);
    check("all_dispatched", assigned, total);
    check("all_completed", completed, total);
`ifdef DISPATCH_PERF_EN
    check("kernel_cycles", kernel_cycles, 1 + cyc);
    tick();
    check("kernel_cycles_hold", kernel_cycles, 1 + cyc);
`endif
    core_done = '0;
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    thread_count = 8'd0;
    core_done    = '0;
    tick();
    check_idle_outputs("por");
    reset = 1'b0;
    tick();
    check_idle_outputs("idle");

    // Eight threads, both cores finish together: +2 completions then done.
    run_kernel(8, 0);

    // Zero threads: no dispatch, done two edges after launch.
    run_kernel(0, 3);

    // Ten threads with core 1 finishing first; start is ignored while running.
    launch(8'd10);
    tick();
    tick();
    check("t10_start", core_start, 2'b11);
    check("t10_ids", core_block_id, 16'h0100);
    check("t10_cnts", core_thread_count, {3'd4, 3'd4});
    start        = 1'b1;
    thread_count = 8'd0;
    core_done    = 2'b10;
    tick();
    check("t10_c1_done_start", core_start, 2'b01);
    check("t10_c1_done_reset", core_reset, 2'b10);
    core_done = 2'b00;
    tick();
    check("t10_pulse_end", core_reset, 2'b00);
    check("t10_no_reassign", core_start, 2'b01);
    tick();
    check("t10_reassign", core_start, 2'b11);
    check("t10_id2", core_block_id[15:8], 8'd2);
    check("t10_cnt2", core_thread_count[5:3], 3'd2);
    start     = 1'b0;
    core_done = 2'b11;
    tick();
    check("t10_final_start", core_start, 2'b00);
    check("t10_final_reset", core_reset, 2'b11);
    check("t10_not_done", done, 1'b0);
    core_done = 2'b00;
    tick();
    check("t10_done", done, 1'b1);

    // Asynchronous reset mid-kernel clears everything and the kernel does not resume.
    launch(8'd8);
    tick();
    tick();
    check("rst_pre_start", core_start, 2'b11);
    #2;
    reset = 1'b1;
    start = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    tick();
    tick();
    check_idle_outputs("rst_held");
    start = 1'b0;
    #2;
    reset = 1'b0;
    tick();
    tick();
    tick();
    check_idle_outputs("rst_no_resume");

    // Boundary and random thread counts.
    run_kernel(1, 4);
    run_kernel(4, 2);
    run_kernel(3, 1);
    run_kernel(255, 6);
    for (int k = 0; k < 6; k++) run_kernel($urandom_range(255, 0), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
